r8_scan_sequencer: RTL

R8_SCAN_SEQUENCER -- requirements
Module: r8_scan_sequencer

---
 rtl/r8_pkg.sv | 25 ++
 rtl/r8_scan_counter.sv | 41 ++++
 rtl/r8_scan_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/r8_pkg.sv
// ============================================================================
// r8_pkg : shared scan-sequencer types, index width and window-width helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package r8_pkg;

  localparam int IDX_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FILL       = 3'd1,
    ST_SLIDE      = 3'd2,
    ST_ROW_END    = 3'd3,
    ST_FRAME_DONE = 3'd4
  } state_t;

  function automatic int win_width(input int radius);
    return 2 * radius + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/r8_scan_counter.sv
// ============================================================================
// r8_scan_counter : column counter wrapping at COLS-1 plus output-row counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module r8_scan_counter
  import r8_pkg::*;
#(
  parameter int COLS = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             col_inc,
  input  logic             row_inc,
  output logic [IDX_W-1:0] col,
  output logic [IDX_W-1:0] row,
  output logic             col_last
);

  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);

  assign col_last = (col == LAST_COL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else begin
      if (col_inc) col <= col_last ? '0 : col + 1'b1;
      if (row_inc) row <= row + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/r8_scan_sequencer.sv
// ============================================================================
// r8_scan_sequencer : sliding-window scan controller for a row-streamed image.
// Optional stall input enabled by defining R8_SEQ_STALL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module r8_scan_sequencer
  import r8_pkg::*;
#(
  parameter int COLS   = 19,
  parameter int ROWS   = 19,
  parameter int RADIUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             valid_i,
`ifdef R8_SEQ_STALL_EN
  input  logic             stall_i,
`endif
  output logic             ld_en,
  output logic             cum_en,
  output logic             sum_en,
  output logic             count_en,
  output logic             start_en,
  output logic             done_o,
  output logic             progress_done_o,
  output logic [IDX_W-1:0] col_o,
  output logic [IDX_W-1:0] row_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int               WIN      = win_width(RADIUS);
  localparam logic [IDX_W-1:0] EDGE_COL = IDX_W'(WIN - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 2 * RADIUS - 1);

  generate
    if (COLS <= 2 * RADIUS || ROWS <= 2 * RADIUS || COLS > 1023) begin : g_param_check
      $error("r8_scan_sequencer: illegal COLS/ROWS/RADIUS combination");
    end
  endgenerate

  state_t state;
  logic   stall;
  logic   run;
  logic   beat;
  logic   drop;
  logic   start_acc;
  logic   col_last;
  logic   row_last;
  logic   at_edge;
  logic   in_fill;

`ifdef R8_SEQ_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  assign run       = !stall;
  assign in_fill   = (state == ST_FILL);
  assign beat      = run && valid_i && (in_fill || state == ST_SLIDE);
  // Beats arriving outside an active row are discarded and flagged.
  assign drop      = run && valid_i &&
                     (state == ST_IDLE || state == ST_ROW_END || state == ST_FRAME_DONE);
  assign start_acc = run && start_i && (state == ST_IDLE || state == ST_FRAME_DONE);
  assign at_edge   = (col_o == EDGE_COL);
  assign row_last  = (row_o == LAST_ROW);

  assign ld_en    = beat && in_fill && (col_o == '0);
  assign cum_en   = beat && in_fill && (col_o != '0);
  assign start_en = beat && in_fill && at_edge;
  assign sum_en   = beat && (state == ST_SLIDE);
  assign count_en = beat;

  r8_scan_counter #(
    .COLS (COLS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_acc),
    .col_inc  (beat),
    .row_inc  (run && state == ST_ROW_END),
    .col      (col_o),
    .row      (row_o),
    .col_last (col_last)
  );

  // Registered outputs freeze while stalled so a pending done_o is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      done_o          <= 1'b0;
      progress_done_o <= 1'b0;
      busy_o          <= 1'b0;
      err_o           <= 1'b0;
    end else if (run) begin
      done_o          <= beat && (col_o >= EDGE_COL);
      progress_done_o <= beat && col_last && row_last;
      err_o           <= drop || (err_o && !start_acc);
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state  <= ST_FILL;
            busy_o <= 1'b1;
          end
        end
        ST_FILL: begin
          if (beat && at_edge) state <= col_last ? ST_ROW_END : ST_SLIDE;
        end
        ST_SLIDE: begin
          if (beat && col_last) state <= ST_ROW_END;
        end
        ST_ROW_END: begin
          if (row_last) begin
            state  <= ST_FRAME_DONE;
            busy_o <= 1'b0;
          end else begin
            state  <= ST_FILL;
          end
        end
        ST_FRAME_DONE: begin
          if (start_i) begin
            state  <= ST_FILL;
            busy_o <= 1'b1;
          end else begin
            state  <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
